// File: rtl/missile_scheduler.sv
// missile_scheduler: shares a pool of missile slots between the player robot and the enemy dragon.
// Optional build macro MISSILE_HIT_EN adds hit_clr to retire flying missiles early.
module missile_scheduler #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned STEP      = 50,
  parameter int unsigned CD_TICKS  = 10,
  parameter int unsigned X_MAX     = 640
) (
  input  logic                      clk_22,
  input  logic                      rst,
  input  logic                      pause,
  input  logic                      req_p,
  input  logic                      req_e,
  input  logic [9:0]                p_x,
  input  logic [9:0]                p_y,
  input  logic [9:0]                e_x,
  input  logic [9:0]                e_y,
`ifdef MISSILE_HIT_EN
  input  logic [NUM_SLOTS-1:0]      hit_clr,
`endif
  output logic                      grant_p,
  output logic                      grant_e,
  output logic [NUM_SLOTS-1:0]      slot_active,
  output logic [NUM_SLOTS-1:0]      slot_owner,
  output logic [10*NUM_SLOTS-1:0]   slot_x,
  output logic [10*NUM_SLOTS-1:0]   slot_y,
  output logic                      busy,
  output logic                      cd_sign
);

  localparam int unsigned CNT_W   = (CD_TICKS > 1) ? $clog2(CD_TICKS) : 1;
  localparam logic [10:0] STEP_11 = 11'(STEP);
  localparam logic [10:0] XMAX_11 = 11'(X_MAX);
  localparam logic [9:0]  STEP_10 = 10'(STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CD_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FLY  = 2'b01,
    S_CD   = 2'b10
  } slot_st_e;

  slot_st_e             st_q  [NUM_SLOTS];
  slot_st_e             st_d  [NUM_SLOTS];
  logic [9:0]           x_q   [NUM_SLOTS];
  logic [9:0]           x_d   [NUM_SLOTS];
  logic [9:0]           y_q   [NUM_SLOTS];
  logic [9:0]           y_d   [NUM_SLOTS];
  logic [CNT_W-1:0]     cnt_q [NUM_SLOTS];
  logic [CNT_W-1:0]     cnt_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] owner_q, owner_d;

  logic pend_p_q, pend_p_d, pend_e_q, pend_e_d;
  logic hist_p_q, hist_p_d, hist_e_q, hist_e_d;
  logic rr_last_q, rr_last_d;   // 1 = enemy won the last tie
  logic grant_p_q, grant_p_d, grant_e_q, grant_e_d;

  logic [NUM_SLOTS-1:0] alloc_oh;
  logic                 free_found;
  logic                 win_p, win_e;
  logic [10:0]          x_fwd;

  // Next-state: request capture, arbitration, allocation and per-slot motion
  always_comb begin
    st_d       = st_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    pend_p_d   = pend_p_q;
    pend_e_d   = pend_e_q;
    hist_p_d   = hist_p_q;
    hist_e_d   = hist_e_q;
    rr_last_d  = rr_last_q;
    grant_p_d  = 1'b0;
    grant_e_d  = 1'b0;
    alloc_oh   = '0;
    free_found = 1'b0;
    win_p      = 1'b0;
    win_e      = 1'b0;
    x_fwd      = '0;

    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && st_q[i] == S_IDLE) begin
        free_found  = 1'b1;
        alloc_oh[i] = 1'b1;
      end
    end

    if (!pause) begin
      hist_p_d = req_p;
      hist_e_d = req_e;

      if (free_found) begin
        if (pend_p_q && pend_e_q) begin
          win_p     = rr_last_q;
          win_e     = ~rr_last_q;
          rr_last_d = ~rr_last_q;
        end else begin
          win_p = pend_p_q;
          win_e = pend_e_q;
        end
      end

      // A rise while already pending (or while being granted) is absorbed
      pend_p_d  = win_p ? 1'b0 : (pend_p_q | (req_p & ~hist_p_q));
      pend_e_d  = win_e ? 1'b0 : (pend_e_q | (req_e & ~hist_e_q));
      grant_p_d = win_p;
      grant_e_d = win_e;

      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        case (st_q[i])
          S_IDLE: begin
            if ((win_p || win_e) && alloc_oh[i]) begin
              st_d[i]    = S_FLY;
              x_d[i]     = win_p ? p_x : e_x;
              y_d[i]     = win_p ? p_y : e_y;
              owner_d[i] = win_e;
            end
          end
          S_FLY: begin
            x_fwd = {1'b0, x_q[i]} + STEP_11;
            if (!owner_q[i]) begin
              if (x_fwd >= XMAX_11) st_d[i] = S_CD;
              else                  x_d[i]  = x_fwd[9:0];
            end else begin
              if (x_q[i] < STEP_10) st_d[i] = S_CD;
              else                  x_d[i]  = x_q[i] - STEP_10;
            end
          end
          S_CD: begin
            if (cnt_q[i] == CNT_LAST) begin
              st_d[i]  = S_IDLE;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: st_d[i] = S_IDLE;
        endcase
      end
    end

`ifdef MISSILE_HIT_EN
    // Hits override motion and are honoured even while paused
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (st_q[i] == S_FLY && hit_clr[i]) begin
        st_d[i] = S_CD;
        x_d[i]  = x_q[i];
      end
    end
`endif
  end

  always_ff @(posedge clk_22) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]  <= S_IDLE;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
      owner_q   <= '0;
      pend_p_q  <= 1'b0;
      pend_e_q  <= 1'b0;
      hist_p_q  <= 1'b0;
      hist_e_q  <= 1'b0;
      rr_last_q <= 1'b1;
      grant_p_q <= 1'b0;
      grant_e_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      pend_p_q  <= pend_p_d;
      pend_e_q  <= pend_e_d;
      hist_p_q  <= hist_p_d;
      hist_e_q  <= hist_e_d;
      rr_last_q <= rr_last_d;
      grant_p_q <= grant_p_d;
      grant_e_q <= grant_e_d;
    end
  end

  // Renderer-facing status decoded from slot state
  always_comb begin
    slot_active = '0;
    slot_x      = '0;
    slot_y      = '0;
    busy        = 1'b1;
    cd_sign     = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_active[i]    = (st_q[i] == S_FLY);
      slot_x[10*i +: 10] = x_q[i];
      slot_y[10*i +: 10] = y_q[i];
      if (st_q[i] == S_IDLE) busy    = 1'b0;
      if (st_q[i] == S_CD)   cd_sign = 1'b1;
    end
  end

  assign slot_owner = owner_q;
  assign grant_p    = grant_p_q;
  assign grant_e    = grant_e_q;

endmodule

// File: tb/tb_missile_scheduler.sv
// Scoreboard bench for missile_scheduler: launches are queued when fired and checked on grant.
module tb_missile_scheduler;

  localparam int unsigned N = 4;

  logic          clk_22 = 1'b0;
  logic          rst, pause, req_p, req_e;
  logic [9:0]    p_x, p_y, e_x, e_y;
  logic          grant_p, grant_e, busy, cd_sign;
  logic [N-1:0]  slot_active, slot_owner;
  logic [10*N-1:0] slot_x, slot_y;
`ifdef MISSILE_HIT_EN
  logic [N-1:0]  hit_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   slot;
    logic owner;
    int   x;
    int   y;
  } exp_t;
  exp_t exp_q[$];

  missile_scheduler #(.NUM_SLOTS(N), .STEP(50), .CD_TICKS(10), .X_MAX(640)) dut (
    .clk_22      (clk_22),
    .rst         (rst),
    .pause       (pause),
    .req_p       (req_p),
    .req_e       (req_e),
    .p_x         (p_x),
    .p_y         (p_y),
    .e_x         (e_x),
    .e_y         (e_y),
`ifdef MISSILE_HIT_EN
    .hit_clr     (hit_clr),
`endif
    .grant_p     (grant_p),
    .grant_e     (grant_e),
    .slot_active (slot_active),
    .slot_owner  (slot_owner),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .busy        (busy),
    .cd_sign     (cd_sign)
  );

  always #5 clk_22 = ~clk_22;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_22);
    #1;
  endtask

  function automatic logic [9:0] sx(input int i);
    return slot_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return slot_y[10*i +: 10];
  endfunction

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget && !(slot_active == '0 && !cd_sign)) begin
      tick();
      k++;
    end
    chk("idle_reached", 32'(slot_active == '0 && !cd_sign), 1);
  endtask

  // Launch monitor: every grant must match the oldest queued launch
  always @(negedge clk_22) begin
    if (grant_p || grant_e) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", {30'd0, grant_p, grant_e}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_grant_e", 32'(grant_e), 32'(e.owner));
        chk("sb_grant_p", 32'(grant_p), 32'(!e.owner));
        chk("sb_active", 32'(slot_active[e.slot]), 1);
        chk("sb_owner", 32'(slot_owner[e.slot]), 32'(e.owner));
        chk("sb_x", 32'(sx(e.slot)), e.x);
        chk("sb_y", 32'(sy(e.slot)), e.y);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, ngr;
    rst = 1'b1; pause = 1'b0; req_p = 1'b0; req_e = 1'b0;
    p_x = '0; p_y = '0; e_x = '0; e_y = '0;
`ifdef MISSILE_HIT_EN
    hit_clr = '0;
`endif
    tick(); tick();
    chk("rst_active", 32'(slot_active), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cd", 32'(cd_sign), 0);
    chk("rst_grant", {30'd0, grant_p, grant_e}, 0);
    chk("rst_x0", 32'(sx(0)), 0);
    chk("rst_owner", 32'(slot_owner), 0);

    // Single player shot across the screen, then cooldown
    rst = 1'b0; p_x = 10'd100; p_y = 10'd140; req_p = 1'b1;
    exp_q.push_back('{0, 1'b0, 100, 140});
    tick(); chk("t1_pend_no_grant", 32'(grant_p), 0);
    tick(); chk("t1_grant", 32'(grant_p), 1);
    tick(); chk("t1_pulse_end", 32'(grant_p), 0);
    chk("t1_x150", 32'(sx(0)), 150);
    for (int k = 2; k <= 10; k++) begin
      tick(); chk("t1_fly_x", 32'(sx(0)), 100 + 50 * k);
    end
    tick();
    chk("t1_cd", 32'(cd_sign), 1);
    chk("t1_not_active", 32'(slot_active[0]), 0);
    chk("t1_x_held", 32'(sx(0)), 600);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!cd_sign) break;
      cnt++;
    end
    chk("t1_cd_len", 32'(cnt), 10);
    chk("t1_idle_busy", 32'(busy), 0);
    req_p = 1'b0;
    tick();

    // Simultaneous fire: player wins the first tie
    p_x = 10'd20; p_y = 10'd30; e_x = 10'd500; e_y = 10'd60;
    req_p = 1'b1; req_e = 1'b1;
    exp_q.push_back('{0, 1'b0, 20, 30});
    exp_q.push_back('{1, 1'b1, 500, 60});
    tick();
    tick(); chk("t2_first_p", {30'd0, grant_p, grant_e}, 2);
    tick(); chk("t2_second_e", {30'd0, grant_p, grant_e}, 1);
    req_p = 1'b0; req_e = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(); chk("t2_enemy_x", 32'(sx(1)), 500 - 50 * k);
    end
    tick();
    chk("t2_enemy_done", 32'(slot_active[1]), 0);
    chk("t2_enemy_x0", 32'(sx(1)), 0);
    chk("t2_cd", 32'(cd_sign), 1);
    wait_idle(60);

    // Second tie: round robin now favours the enemy
    p_x = 10'd300; p_y = 10'd5; e_x = 10'd300; e_y = 10'd6;
    req_p = 1'b1; req_e = 1'b1;
    exp_q.push_back('{0, 1'b1, 300, 6});
    exp_q.push_back('{1, 1'b0, 300, 5});
    tick();
    tick(); chk("t2b_first_e", {30'd0, grant_p, grant_e}, 1);
    tick(); chk("t2b_second_p", {30'd0, grant_p, grant_e}, 2);
    req_p = 1'b0; req_e = 1'b0;
    wait_idle(60);

    // Pool exhaustion
    p_x = 10'd0;
    for (int i = 0; i < 4; i++) begin
      p_y = 10'(10 * (i + 1));
      exp_q.push_back('{i, 1'b0, 0, 10 * (i + 1)});
      req_p = 1'b1; tick();
      req_p = 1'b0; tick();
    end
    chk("t3_busy", 32'(busy), 1);
    p_y = 10'd99;
    exp_q.push_back('{0, 1'b0, 0, 99});
    req_p = 1'b1;
    ngr = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (!busy) break;
      if (grant_p) ngr++;
    end
    chk("t3_no_grant_busy", 32'(ngr), 0);
    chk("t3_freed", 32'(busy), 0);
    chk("t3_free_no_grant", 32'(grant_p), 0);
    tick();
    chk("t3_late_grant", 32'(grant_p), 1);
    chk("t3_slot0_fly", 32'(slot_active[0]), 1);
    req_p = 1'b0;
    wait_idle(80);

    // Level-held request launches exactly once
    p_x = 10'd200; p_y = 10'd77;
    exp_q.push_back('{0, 1'b0, 200, 77});
    req_p = 1'b1;
    ngr = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (grant_p) ngr++;
    end
    chk("t4_one_grant", 32'(ngr), 1);
    req_p = 1'b0;
    wait_idle(60);

    // Pause freezes flight and cooldown and ignores request pulses
    e_x = 10'd600; e_y = 10'd11; p_x = 10'd600; p_y = 10'd12;
    exp_q.push_back('{0, 1'b1, 600, 11});
    exp_q.push_back('{1, 1'b0, 600, 12});
    req_e = 1'b1; tick();
    tick(); chk("t5_grant_e", 32'(grant_e), 1);
    req_e = 1'b0; req_p = 1'b1; tick();
    chk("t5_x550", 32'(sx(0)), 550);
    tick(); chk("t5_grant_p", 32'(grant_p), 1);
    req_p = 1'b0; tick();
    chk("t5_p_cd", 32'(cd_sign), 1);
    tick();
    chk("t5_x400", 32'(sx(0)), 400);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_e = k[0];
      tick();
      chk("t5_pause_x", 32'(sx(0)), 400);
      chk("t5_pause_cd", 32'(cd_sign), 1);
      chk("t5_pause_grant", {30'd0, grant_p, grant_e}, 0);
    end
    req_e = 1'b0; pause = 1'b0;
    tick();
    chk("t5_resume_x", 32'(sx(0)), 350);
    chk("t5_no_grant", 32'(grant_e), 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!cd_sign || slot_owner[1] != 1'b0 || slot_active[1]) break;
      if (sx(1) != 10'd600) break;
      cnt++;
      if (cnt == 7) break;
    end
    chk("t5_cd_remaining", 32'(cnt), 7);
    tick();
    chk("t5_p_slot_idle", 32'(busy), 0);
    wait_idle(60);

`ifdef MISSILE_HIT_EN
    // Hit retires a flying missile in place
    p_x = 10'd150; p_y = 10'd40;
    exp_q.push_back('{0, 1'b0, 150, 40});
    req_p = 1'b1; tick();
    req_p = 1'b0; tick();
    tick(); tick();
    chk("t6_x250", 32'(sx(0)), 250);
    hit_clr = 4'b0001;
    tick();
    hit_clr = '0;
    chk("t6_hit_cd", 32'(cd_sign), 1);
    chk("t6_hit_x", 32'(sx(0)), 250);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!cd_sign) break;
      cnt++;
    end
    chk("t6_cd_len", 32'(cnt), 10);
`endif

    // Reset during cooldown aborts everything
    p_x = 10'd600; p_y = 10'd1;
    exp_q.push_back('{0, 1'b0, 600, 1});
    req_p = 1'b1; tick();
    req_p = 1'b0; tick();
    tick();
    chk("t7_cd_before", 32'(cd_sign), 1);
    rst = 1'b1;
    tick();
    chk("t7_rst_cd", 32'(cd_sign), 0);
    chk("t7_rst_active", 32'(slot_active), 0);
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_x", 32'(sx(0)), 0);
    chk("t7_rst_grant", {30'd0, grant_p, grant_e}, 0);
    rst = 1'b0;
    tick();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/missile_scheduler.md
Name: missile_scheduler

Overview:
- Owns a pool of NUM_SLOTS missile slots and shares them between two shooters: the player robot and the enemy dragon.
- Edge-detects each shooter's fire request and arbitrates round-robin when both fire in the same cycle.
- Allocates the lowest free slot to the winner and then runs that slot through fly, cooldown and idle.
- Sits between the input/AI logic and the VGA renderer, replacing per-shooter single-missile movers.

Parameters:
- NUM_SLOTS, 4, number of missile slots (1..8).
- STEP, 50, pixels moved per clk_22 tick while flying.
- CD_TICKS, 10, clk_22 ticks a slot spends in cooldown before it becomes free.
- X_MAX, 640, exclusive right screen bound.

Ports:
- clk_22 input 1: game tick clock; the only clock.
- rst input 1: synchronous, active-high reset.
- pause input 1: freezes all state while high.
- req_p input 1: player fire request, level input.
- req_e input 1: enemy fire request, level input.
- p_x, p_y input 10 each: player launch position.
- e_x, e_y input 10 each: enemy launch position.
- grant_p output 1: one-cycle pulse when a player missile is launched.
- grant_e output 1: one-cycle pulse when an enemy missile is launched.
- slot_active output NUM_SLOTS: bit i is high while slot i is in FLY.
- slot_owner output NUM_SLOTS: bit i is 0 for a player missile, 1 for an enemy missile.
- slot_x output 10*NUM_SLOTS: slot i x-position in bits [10i+9:10i].
- slot_y output 10*NUM_SLOTS: slot i y-position, same packing.
- busy output 1: no slot is IDLE.
- cd_sign output 1: at least one slot is in CD.

Behaviour:
- Reset (sync, rst=1 at a clk_22 edge) clears:
  - all slots to IDLE; slot_x, slot_y, slot_owner to 0;
  - all cooldown counters to 0;
  - grant_p and grant_e to 0;
  - pend_p and pend_e to 0;
  - request history registers to 0;
  - rr_last to enemy, so the player wins the first tie.
  - Reset mid-flight or mid-cooldown aborts everything, with no grant or cd side effects.
- Request capture, every non-paused edge:
  - pend_x is set on a rising edge of req_x (req_x high while its history register is 0).
  - pend_x stays set until that requester is granted.
  - Holding req high produces exactly one launch. A new rising edge while already pending is absorbed.
- Arbitration, non-paused cycle with at least one IDLE slot:
  - Exactly one pending requester: that requester wins.
  - Both pending: the requester other than rr_last wins, and rr_last is updated to the winner.
  - At most one grant per cycle; the loser stays pending.
  - No IDLE slot: no grant, and pends are held.
- Launch latency, for a grant decided at edge N:
  - grant_x pulses during the cycle following edge N.
  - The chosen slot (lowest-index IDLE) enters FLY at edge N with x,y equal to the requester's launch position sampled at N, and owner set accordingly.
- Slot FSM: IDLE(00) -> FLY(01) -> CD(10) -> IDLE.
  - FLY, player owner: if x+STEP >= X_MAX (compare in 11 bits), go to CD and hold x; else x <= x+STEP.
  - FLY, enemy owner: if x < STEP, go to CD and hold x; else x <= x-STEP.
  - y is constant during flight.
  - CD: the counter increments each tick. When the counter equals CD_TICKS-1, the slot goes to IDLE and the counter clears to 0. CD therefore lasts exactly CD_TICKS ticks.
  - A slot is not allocatable in the same cycle it leaves CD. It is allocatable from the following edge.
- pause=1 holds everything: slots, counters, pends, request history, rr_last. grant_p and grant_e are forced to 0. Rising edges that occur during pause are not captured.
- Combinational outputs:
  - slot_active = per-slot (state==FLY);
  - busy = no slot IDLE;
  - cd_sign = any slot in CD.

Optional Feature:
- Macro MISSILE_HIT_EN, defined:
  - Adds input port hit_clr [NUM_SLOTS-1:0].
  - A FLY slot whose bit is set goes to CD at the next edge with position held. This takes priority over movement and the boundary check.
  - Bits for non-FLY slots are ignored.
  - hit_clr is honoured even while paused, so a hit is never lost.
- Macro MISSILE_HIT_EN, undefined:
  - The port is absent, and slots leave FLY only at the screen boundary.

Test Plan:
1. Reset, then player fire:
   - Stimulus: rst=1 for 2 edges; release; p_x=100, p_y=140; req_p rises.
   - Response: next edge gives grant_p=1 for one cycle and slot0 FLY at x=100, y=140; x then runs 150, 200, ... 600; the edge after 600 gives CD.
   - cd_sign stays high for 10 ticks, then slot0 is IDLE.
2. Simultaneous fire:
   - Stimulus: req_p and req_e rise on the same edge; e_x=500.
   - Response: player is granted first (slot0); the next edge grants enemy (slot1, owner=1); slot1 runs x=450 down to 0, then CD.
3. Pool exhaustion:
   - Stimulus: fire 4 player requests.
   - Response: busy=1; a 5th rising edge gives no grant while busy.
   - When the first slot leaves CD, one edge later the 5th launch is granted into that slot.
4. Level-held request:
   - Stimulus: hold req_p high for 50 ticks.
   - Response: exactly one grant_p pulse.
5. Pause:
   - Stimulus: assert pause mid-flight for 5 ticks while pulsing req_e.
   - Response: slot x, cd counter and pends are unchanged; no grants; on release, motion resumes from the held x.
6. Hit clear (MISSILE_HIT_EN):
   - Stimulus: hit_clr[0]=1 while slot0 is at x=250.
   - Response: CD at x=250 next edge; IDLE after 10 ticks.
   - Also: reset asserted mid-CD gives all IDLE and cd_sign=0 at the next edge.
